// File: rtl/addr_sequencer_if.sv
// Control/handshake bundle for addr_sequencer.
// Carries loop_i only when ADDR_SEQUENCER_LOOP_EN is defined.
interface addr_sequencer_if #(
   parameter int WORD_LENGTH  = 16,
   parameter int STRIDE_WIDTH = 4
);
   logic                    start_i;
   logic                    abort_i;
   logic [WORD_LENGTH-1:0]  base_i;
   logic [WORD_LENGTH-1:0]  count_i;
   logic [STRIDE_WIDTH-1:0] stride_i;
   logic                    down_i;
   logic                    ready_i;
`ifdef ADDR_SEQUENCER_LOOP_EN
   logic                    loop_i;
`endif
   logic                    valid_o;
   logic [WORD_LENGTH-1:0]  addr_o;
   logic                    last_o;
   logic                    busy_o;
   logic                    done_o;

   modport master (
`ifdef ADDR_SEQUENCER_LOOP_EN
      output loop_i,
`endif
      output start_i, abort_i, base_i, count_i, stride_i, down_i, ready_i,
      input  valid_o, addr_o, last_o, busy_o, done_o
   );

   modport slave (
`ifdef ADDR_SEQUENCER_LOOP_EN
      input  loop_i,
`endif
      input  start_i, abort_i, base_i, count_i, stride_i, down_i, ready_i,
      output valid_o, addr_o, last_o, busy_o, done_o
   );
endinterface

// File: rtl/addr_sequencer.sv
// Burst address generator: base/count/stride/direction over valid/ready.
// Optional continuous looping mode enabled by ADDR_SEQUENCER_LOOP_EN.
module addr_sequencer #(
   parameter int WORD_LENGTH  = 16,
   parameter int STRIDE_WIDTH = 4
) (
   input logic             clock_i,
   input logic             reset_i,
   addr_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state, state_next;
   logic [WORD_LENGTH-1:0]  addr, addr_next;
   logic [WORD_LENGTH-1:0]  remaining, remaining_next;
   logic [STRIDE_WIDTH-1:0] stride, stride_next;
   logic                    down, down_next;
   logic                    valid, valid_next;
   logic [WORD_LENGTH-1:0]  step;
   logic [WORD_LENGTH-1:0]  addr_stepped;
   logic                    handshake;
`ifdef ADDR_SEQUENCER_LOOP_EN
   logic [WORD_LENGTH-1:0]  base, base_next;
   logic [WORD_LENGTH-1:0]  count, count_next;
   logic                    loop, loop_next;
   logic                    pass, pass_next;
`endif

   assign step         = WORD_LENGTH'(stride);
   assign addr_stepped = down ? (addr - step) : (addr + step);
   assign handshake    = valid && bus.ready_i;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         stride    <= '0;
         down      <= 1'b0;
         valid     <= 1'b0;
`ifdef ADDR_SEQUENCER_LOOP_EN
         base      <= '0;
         count     <= '0;
         loop      <= 1'b0;
         pass      <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         addr      <= addr_next;
         remaining <= remaining_next;
         stride    <= stride_next;
         down      <= down_next;
         valid     <= valid_next;
`ifdef ADDR_SEQUENCER_LOOP_EN
         base      <= base_next;
         count     <= count_next;
         loop      <= loop_next;
         pass      <= pass_next;
`endif
      end
   end

   always_comb begin
      state_next     = state;
      addr_next      = addr;
      remaining_next = remaining;
      stride_next    = stride;
      down_next      = down;
      valid_next     = valid;
`ifdef ADDR_SEQUENCER_LOOP_EN
      base_next      = base;
      count_next     = count;
      loop_next      = loop;
      pass_next      = 1'b0;
`endif
      case (state)
         IDLE, DONE: begin
            if (bus.start_i) begin
               stride_next = bus.stride_i;
               down_next   = bus.down_i;
`ifdef ADDR_SEQUENCER_LOOP_EN
               base_next   = bus.base_i;
               count_next  = bus.count_i;
               loop_next   = bus.loop_i;
`endif
               if (bus.count_i != '0) begin
                  state_next     = RUN;
                  addr_next      = bus.base_i;
                  remaining_next = bus.count_i;
                  valid_next     = 1'b1;
               end else begin
                  // empty burst: completion pulse without any beat
                  state_next     = DONE;
                  remaining_next = '0;
                  valid_next     = 1'b0;
               end
            end else begin
               state_next = IDLE;
            end
         end

         RUN: begin
            if (bus.abort_i) begin
               state_next     = IDLE;
               valid_next     = 1'b0;
               remaining_next = '0;
            end else if (handshake) begin
               if (remaining == WORD_LENGTH'(1)) begin
`ifdef ADDR_SEQUENCER_LOOP_EN
                  if (loop) begin
                     // reload without a bubble; done marks the new pass
                     addr_next      = base;
                     remaining_next = count;
                     pass_next      = 1'b1;
                  end else begin
                     state_next     = DONE;
                     valid_next     = 1'b0;
                     remaining_next = '0;
                  end
`else
                  state_next     = DONE;
                  valid_next     = 1'b0;
                  remaining_next = '0;
`endif
               end else begin
                  addr_next      = addr_stepped;
                  remaining_next = remaining - WORD_LENGTH'(1);
               end
            end
         end

         default: begin
            state_next     = IDLE;
            valid_next     = 1'b0;
            remaining_next = '0;
         end
      endcase
   end

   assign bus.valid_o = valid;
   assign bus.addr_o  = addr;
   assign bus.last_o  = valid && (remaining == WORD_LENGTH'(1));
   assign bus.busy_o  = (state == RUN);
`ifdef ADDR_SEQUENCER_LOOP_EN
   assign bus.done_o  = (state == DONE) || pass;
`else
   assign bus.done_o  = (state == DONE);
`endif

endmodule

// File: tb/tb_addr_sequencer.sv
// Self-checking bench for addr_sequencer: vector table, corner sequences,
// and randomized bursts against an arithmetic address model.
`timescale 1ns/1ps
module tb_addr_sequencer;
   localparam int WL = 16;
   localparam int SW = 4;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   addr_sequencer_if #(.WORD_LENGTH(WL), .STRIDE_WIDTH(SW)) bus ();

   addr_sequencer #(.WORD_LENGTH(WL), .STRIDE_WIDTH(SW)) dut (
      .clock_i (clk),
      .reset_i (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WL-1:0] base;
      logic [WL-1:0] count;
      logic [SW-1:0] stride;
      logic          down;
      int            mode;
      logic [WL-1:0] exp_first;
      logic [WL-1:0] exp_last;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic pick_ready(input int mode, input int cyc);
      logic [3:0] pat;
      pat = 4'b1001;
      case (mode)
         0:       return 1'b1;
         1:       return pat[3 - (cyc % 4)];
         default: return 1'($urandom % 2);
      endcase
   endfunction

   task automatic check_quiet(input string tag);
      check({tag, "_valid"}, 32'(bus.valid_o), 32'd0);
      check({tag, "_busy"},  32'(bus.busy_o),  32'd0);
      check({tag, "_last"},  32'(bus.last_o),  32'd0);
   endtask

   // Called right after a negedge; returns right after a negedge.
   task automatic run_burst(input logic [WL-1:0] b, input logic [WL-1:0] n,
                            input logic [SW-1:0] s, input logic d, input int mode,
                            input int inj, input int abort_at,
                            output logic [WL-1:0] first, output logic [WL-1:0] lastaddr);
      logic [WL-1:0] expq[$];
      int            k;
      int            cyc;
      int            budget;
      logic          rdy;
      for (int i = 0; i < int'(n); i++)
         expq.push_back(d ? b - WL'(i * int'(s)) : b + WL'(i * int'(s)));
      first    = '0;
      lastaddr = '0;
      k        = 0;
      cyc      = 0;
      budget   = 20 * int'(n) + 20;
      bus.start_i  = 1'b1;
      bus.base_i   = b;
      bus.count_i  = n;
      bus.stride_i = s;
      bus.down_i   = d;
      bus.ready_i  = pick_ready(mode, 0);
      @(negedge clk);
      bus.start_i = 1'b0;
      if (n == '0) begin
         check("zero_done", 32'(bus.done_o), 32'd1);
         check_quiet("zero");
         @(negedge clk);
         check("zero_done_clear", 32'(bus.done_o), 32'd0);
         return;
      end
      while (k < int'(n) && cyc < budget) begin
         check("beat_valid", 32'(bus.valid_o), 32'd1);
         check("beat_busy",  32'(bus.busy_o),  32'd1);
         check("beat_done",  32'(bus.done_o),  32'd0);
         check("beat_addr",  32'(bus.addr_o),  32'(expq[k]));
         check("beat_last",  32'(bus.last_o),  32'(k == int'(n) - 1));
         if (k == abort_at) begin
            bus.abort_i = 1'b1;
            bus.ready_i = 1'b1;
            @(negedge clk);
            bus.abort_i = 1'b0;
            bus.ready_i = 1'b0;
            check_quiet("abort");
            check("abort_done", 32'(bus.done_o), 32'd0);
            return;
         end
         rdy = pick_ready(mode, cyc);
         bus.ready_i = rdy;
         if (cyc == inj) begin
            bus.start_i  = 1'b1;
            bus.base_i   = 16'hDEAD;
            bus.count_i  = 16'd2;
            bus.stride_i = 4'd7;
            bus.down_i   = ~d;
         end else begin
            bus.start_i = 1'b0;
         end
         if (rdy) begin
            if (k == 0) first = bus.addr_o;
            if (k == int'(n) - 1) lastaddr = bus.addr_o;
            k++;
         end
         @(negedge clk);
         cyc++;
      end
      bus.start_i = 1'b0;
      bus.ready_i = 1'b0;
      if (k < int'(n)) begin
         check("burst_timeout", 32'(k), 32'(n));
         return;
      end
      check("end_done", 32'(bus.done_o), 32'd1);
      check_quiet("end");
      @(negedge clk);
      check("end_done_clear", 32'(bus.done_o), 32'd0);
      check("end_busy_idle",  32'(bus.busy_o), 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [WL-1:0] f, l;
      rst          = 1'b1;
      bus.start_i  = 1'b1;
      bus.abort_i  = 1'b0;
      bus.base_i   = 16'h1234;
      bus.count_i  = 16'd4;
      bus.stride_i = 4'd1;
      bus.down_i   = 1'b0;
      bus.ready_i  = 1'b1;
`ifdef ADDR_SEQUENCER_LOOP_EN
      bus.loop_i   = 1'b0;
`endif
      vecs[0] = '{16'h0010, 16'd4, 4'd2,  1'b0, 0, 16'h0010, 16'h0016};
      vecs[1] = '{16'h0010, 16'd4, 4'd2,  1'b0, 1, 16'h0010, 16'h0016};
      vecs[2] = '{16'h0001, 16'd3, 4'd2,  1'b1, 0, 16'h0001, 16'hFFFD};
      vecs[3] = '{16'hFFFE, 16'd3, 4'd1,  1'b0, 1, 16'hFFFE, 16'h0000};
      vecs[4] = '{16'h1234, 16'd5, 4'd0,  1'b0, 2, 16'h1234, 16'h1234};
      vecs[5] = '{16'h8000, 16'd2, 4'd15, 1'b1, 0, 16'h8000, 16'h7FF1};

      // reset overrides a pending start
      @(negedge clk);
      @(negedge clk);
      check_quiet("reset");
      check("reset_addr", 32'(bus.addr_o), 32'd0);
      check("reset_done", 32'(bus.done_o), 32'd0);
      rst         = 1'b0;
      bus.start_i = 1'b0;
      bus.ready_i = 1'b0;
      @(negedge clk);
      check_quiet("post_reset");

      for (int i = 0; i < 6; i++) begin
         run_burst(vecs[i].base, vecs[i].count, vecs[i].stride, vecs[i].down,
                   vecs[i].mode, -1, -1, f, l);
         check($sformatf("vec%0d_first", i), 32'(f), 32'(vecs[i].exp_first));
         check($sformatf("vec%0d_last", i),  32'(l), 32'(vecs[i].exp_last));
      end

      // empty burst, then start during RUN ignored
      run_burst(16'h0042, 16'd0, 4'd3, 1'b0, 0, -1, -1, f, l);
      run_burst(16'h0100, 16'd8, 4'd1, 1'b0, 0, 2, -1, f, l);
      check("ignored_start_last", 32'(l), 32'h0107);

      // abort on the third beat, then immediate restart
      run_burst(16'h0200, 16'd8, 4'd4, 1'b0, 0, -1, 2, f, l);
      run_burst(16'h0300, 16'd2, 4'd1, 1'b0, 0, -1, -1, f, l);
      check("restart_first", 32'(f), 32'h0300);

      // reset mid-burst
      bus.start_i  = 1'b1;
      bus.base_i   = 16'h0500;
      bus.count_i  = 16'd8;
      bus.stride_i = 4'd1;
      bus.down_i   = 1'b0;
      bus.ready_i  = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("pre_reset_addr", 32'(bus.addr_o), 32'h0502);
      rst = 1'b1;
      @(negedge clk);
      check_quiet("midreset");
      check("midreset_addr", 32'(bus.addr_o), 32'd0);
      check("midreset_done", 32'(bus.done_o), 32'd0);
      rst         = 1'b0;
      bus.ready_i = 1'b0;
      @(negedge clk);

`ifdef ADDR_SEQUENCER_LOOP_EN
      bus.loop_i   = 1'b1;
      bus.start_i  = 1'b1;
      bus.base_i   = 16'h0020;
      bus.count_i  = 16'd2;
      bus.stride_i = 4'd1;
      bus.down_i   = 1'b0;
      bus.ready_i  = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.loop_i  = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check("loop_valid", 32'(bus.valid_o), 32'd1);
         check("loop_addr",  32'(bus.addr_o),  32'h20 + 32'(i % 2));
         check("loop_last",  32'(bus.last_o),  32'(i % 2 == 1));
         check("loop_done",  32'(bus.done_o),  32'(i >= 2 && i % 2 == 0));
         @(negedge clk);
      end
      bus.abort_i = 1'b1;
      @(negedge clk);
      bus.abort_i = 1'b0;
      bus.ready_i = 1'b0;
      check_quiet("loop_abort");
      check("loop_abort_done", 32'(bus.done_o), 32'd0);
      @(negedge clk);
`endif

      for (int t = 0; t < 40; t++) begin
         run_burst(WL'($urandom), WL'($urandom_range(0, 12)), SW'($urandom_range(0, 15)),
                   1'($urandom % 2), int'($urandom_range(0, 2)), -1, -1, f, l);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/addr_sequencer.md
Name: addr_sequencer

Overview:
- Parametrised address generator; successor to the plain enable-driven address counter.
- Emits a programmed burst of addresses from a base, with configurable stride and direction, over a valid/ready handshake.
- Tracks remaining count; flags the last beat; pulses done on completion.
- Sits between control logic and memory/BRAM address ports; one instance per address stream.

Parameters:
- WORD_LENGTH, 16, width of addresses and burst count.
- STRIDE_WIDTH, 4, width of stride input (unsigned).

Ports:
- clock_i  in  1  clock; all state on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  start request; accepted only while busy_o=0.
- abort_i  in  1  cancel current burst.
- base_i  in  WORD_LENGTH  first address, latched on accepted start.
- count_i  in  WORD_LENGTH  number of addresses to emit, latched on start.
- stride_i  in  STRIDE_WIDTH  address step, latched on start.
- down_i  in  1  0=increment, 1=decrement; latched on start.
- ready_i  in  1  consumer accepts addr_o this cycle.
- valid_o  out  1  addr_o valid.
- addr_o  out  WORD_LENGTH  current address (registered).
- last_o  out  1  current beat is final of burst.
- busy_o  out  1  burst in progress (RUN state).
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset_i=1 at edge, overrides everything): state IDLE; valid_o=0, addr_o=0, last_o=0, busy_o=0, done_o=0; remaining count=0.
- States: IDLE, RUN, DONE. busy_o=1 exactly in RUN; done_o=1 exactly in DONE.
- IDLE/DONE + start_i, count_i!=0: next state RUN; addr_o<=base_i, valid_o<=1. First valid beat is 1 cycle after start.
- IDLE/DONE + start_i, count_i=0: next state DONE (done_o pulse, no valid beat).
- DONE without start_i: returns to IDLE next cycle.
- start_i in RUN: ignored.
- RUN, valid_o&ready_i:
  - remaining=1: next state DONE, valid_o<=0.
  - otherwise: addr_o <= addr_o ± stride (modulo 2^WORD_LENGTH, wraps silently both directions); remaining decrements.
- RUN, ready_i=0: addr_o, valid_o, last_o held stable (AXI-style; no retraction).
- last_o = valid_o && remaining==1; combinationally derived from registered state only, no input paths.
- stride_i=0 is legal: same address emitted count_i times.
- abort_i in RUN (priority over handshake): next state IDLE, valid_o<=0, no done_o pulse; beat accepted in the same cycle is considered cancelled. abort_i outside RUN ignored.
- Throughput: one address per cycle with ready_i held high; burst of N takes N+1 cycles from start to done_o.

Optional Feature:
- Macro: ADDR_SEQUENCER_LOOP_EN.
- Defined:
  - Adds input loop_i (1 bit), latched on start.
  - If latched loop=1, final handshake reloads addr_o<=base, remaining<=count and stays in RUN with no bubble.
  - done_o pulses for one cycle coincident with the first reloaded beat (pass marker).
  - Exit only via abort_i or reset_i.
- Undefined: no loop_i port; behaviour exactly as above.

Test Plan:
- Reset, then start base=0x0010, count=4, stride=2, up, ready=1 -> addr 0x0010,0x0012,0x0014,0x0016 on consecutive cycles; last_o on 0x0016; done_o next cycle; busy_o low after.
- Same burst with ready_i toggled 1,0,0,1,... -> addr_o/last_o stable during stalls; exactly 4 accepted beats in order.
- base=0x0001, count=3, stride=2, down=1, WORD_LENGTH=16 -> 0x0001,0xFFFF,0xFFFD; done_o once.
- start with count=0 -> no valid_o; done_o pulse 1 cycle later; start_i during RUN of 8-beat burst -> ignored, burst unchanged.
- abort_i on 3rd beat of count=8 -> valid_o=0 next cycle, no done_o, state IDLE; new start accepted immediately. reset_i mid-burst -> all outputs 0 next cycle.
- (ADDR_SEQUENCER_LOOP_EN) loop=1, base=0x20, count=2, stride=1 -> 0x20,0x21,0x20,0x21,... with done_o on each 0x20 after the first; abort_i stops.
